// File: rtl/salamander_sram_arbiter_if.sv
// Bus bundle between the two masters, the arbiter and the single-port SRAM.
// The arbiter uses the slave view. The environment (video, CPU and SRAM) uses the master view.
interface salamander_sram_arbiter_if #(
    parameter int AW = 10,
    parameter int DW = 8
);
    // video scan-out read port
    logic          i_VID_REQ;
    logic [AW-1:0] i_VID_ADDR;
    logic [DW-1:0] o_VID_DATA;
    logic          o_VID_VALID;
    // CPU read/write port with wait-state handshake
    logic          i_CPU_REQ;
    logic          i_CPU_WE;
    logic [AW-1:0] i_CPU_ADDR;
    logic [DW-1:0] i_CPU_DIN;
    logic [DW-1:0] o_CPU_DOUT;
    logic          o_CPU_ACK;
    // SRAM side
    logic [AW-1:0] o_RAM_ADDR;
    logic [DW-1:0] o_RAM_DIN;
    logic          o_RAM_RD;
    logic          o_RAM_WR;
    logic [DW-1:0] i_RAM_DOUT;
    // status
    logic          o_INIT_BUSY;

    modport slave (
        input  i_VID_REQ, i_VID_ADDR, i_CPU_REQ, i_CPU_WE, i_CPU_ADDR, i_CPU_DIN, i_RAM_DOUT,
        output o_VID_DATA, o_VID_VALID, o_CPU_DOUT, o_CPU_ACK,
        output o_RAM_ADDR, o_RAM_DIN, o_RAM_RD, o_RAM_WR, o_INIT_BUSY
    );

    modport master (
        output i_VID_REQ, i_VID_ADDR, i_CPU_REQ, i_CPU_WE, i_CPU_ADDR, i_CPU_DIN, i_RAM_DOUT,
        input  o_VID_DATA, o_VID_VALID, o_CPU_DOUT, o_CPU_ACK,
        input  o_RAM_ADDR, o_RAM_DIN, o_RAM_RD, o_RAM_WR, o_INIT_BUSY
    );
endinterface

// File: rtl/salamander_sram_arbiter.sv
// Two-master front end for a single-port SRAM.
// Video reads have priority. The CPU uses a request/ack handshake and is protected from starvation.
// The RAM is cleared after reset. Every access runs through a three-stage registered pipeline:
// grant, then SRAM access, then return.
module salamander_sram_arbiter #(
    parameter int            AW         = 10,
    parameter int            DW         = 8,
    parameter int            STARVE     = 4,
    parameter int            INIT_CLEAR = 1,
    parameter logic [DW-1:0] CLR_VAL    = '0
) (
    input  logic                      i_MCLK,
    input  logic                      i_RST_n,
    salamander_sram_arbiter_if.slave  bus
);
    localparam int SW = $clog2(STARVE + 1);
    localparam logic [SW-1:0] STARVE_MAX = SW'(STARVE);

    typedef enum logic {ST_INIT, ST_RUN} state_t;
    // OP_VID_CLR is a video read issued during the clear: it returns CLR_VAL without touching the RAM
    typedef enum logic [2:0] {OP_NONE, OP_VID, OP_VID_CLR, OP_CPU_RD, OP_CPU_WR} op_t;

    state_t        state_q;
    logic [AW-1:0] clr_cnt_q;
    logic [SW-1:0] starve_q, starve_d;
    logic          pend_q, pend_d;
    logic [AW-1:0] pend_addr_q, pend_addr_d;
    op_t           s1_q, s2_q;
    logic [AW-1:0] ram_addr_q;
    logic [DW-1:0] ram_din_q;
    logic          ram_rd_q, ram_wr_q;
    logic [DW-1:0] vid_data_q, cpu_dout_q;
    logic          vid_valid_q, cpu_ack_q, busy_q;

    logic          cpu_elig, grant_vid, grant_cpu;
    logic [AW-1:0] grant_addr;

    // Grant decision for this edge, plus the pending-slot and starvation bookkeeping.
    // The CPU can be eligible during the clear. It then builds up starvation credit and
    // may be forced ahead of video on the first RUN edge.
    always_comb begin
        cpu_elig    = bus.i_CPU_REQ
                      && (s1_q != OP_CPU_RD) && (s1_q != OP_CPU_WR)
                      && (s2_q != OP_CPU_RD) && (s2_q != OP_CPU_WR)
                      && !cpu_ack_q;
        grant_vid   = 1'b0;
        grant_cpu   = 1'b0;
        grant_addr  = bus.i_VID_ADDR;
        pend_d      = pend_q;
        pend_addr_d = pend_addr_q;
        if (state_q == ST_RUN) begin
            if (pend_q) begin
                grant_vid   = 1'b1;
                grant_addr  = pend_addr_q;
                pend_d      = bus.i_VID_REQ;
                pend_addr_d = bus.i_VID_ADDR;
            end else if (cpu_elig && (starve_q == STARVE_MAX)) begin
                grant_cpu  = 1'b1;
                grant_addr = bus.i_CPU_ADDR;
                if (bus.i_VID_REQ) begin
                    pend_d      = 1'b1;
                    pend_addr_d = bus.i_VID_ADDR;
                end
            end else if (bus.i_VID_REQ) begin
                grant_vid = 1'b1;
            end else if (cpu_elig) begin
                grant_cpu  = 1'b1;
                grant_addr = bus.i_CPU_ADDR;
            end
        end
        if (grant_cpu || !bus.i_CPU_REQ) begin
            starve_d = '0;
        end else if (cpu_elig && (starve_q != STARVE_MAX)) begin
            starve_d = starve_q + 1'b1;
        end else begin
            starve_d = starve_q;
        end
    end

    // FSM, RAM command register, access pipeline and return registers.
    always_ff @(posedge i_MCLK or negedge i_RST_n) begin
        if (!i_RST_n) begin
            state_q     <= (INIT_CLEAR != 0) ? ST_INIT : ST_RUN;
            busy_q      <= (INIT_CLEAR != 0);
            clr_cnt_q   <= '0;
            starve_q    <= '0;
            pend_q      <= 1'b0;
            pend_addr_q <= '0;
            s1_q        <= OP_NONE;
            s2_q        <= OP_NONE;
            ram_addr_q  <= '0;
            ram_din_q   <= '0;
            ram_rd_q    <= 1'b0;
            ram_wr_q    <= 1'b0;
            vid_data_q  <= '0;
            vid_valid_q <= 1'b0;
            cpu_dout_q  <= '0;
            cpu_ack_q   <= 1'b0;
        end else begin
            starve_q    <= starve_d;
            pend_q      <= pend_d;
            pend_addr_q <= pend_addr_d;
            s2_q        <= s1_q;

            // return stage: the SRAM output for the access issued two edges ago is valid now
            vid_valid_q <= 1'b0;
            cpu_ack_q   <= 1'b0;
            case (s2_q)
                OP_VID:     begin vid_data_q <= bus.i_RAM_DOUT; vid_valid_q <= 1'b1; end
                OP_VID_CLR: begin vid_data_q <= CLR_VAL;        vid_valid_q <= 1'b1; end
                OP_CPU_RD:  begin cpu_dout_q <= bus.i_RAM_DOUT; cpu_ack_q   <= 1'b1; end
                OP_CPU_WR:  cpu_ack_q <= 1'b1;
                default:    ;
            endcase

            // command stage: idle cycles keep the address and data and drop both strobes
            ram_rd_q <= 1'b0;
            ram_wr_q <= 1'b0;
            s1_q     <= OP_NONE;
            if (state_q == ST_INIT) begin
                ram_wr_q   <= 1'b1;
                ram_addr_q <= clr_cnt_q;
                ram_din_q  <= CLR_VAL;
                clr_cnt_q  <= clr_cnt_q + 1'b1;
                if (bus.i_VID_REQ) begin
                    s1_q <= OP_VID_CLR;
                end
                if (&clr_cnt_q) begin
                    state_q <= ST_RUN;
                    busy_q  <= 1'b0;
                end
            end else if (grant_vid) begin
                ram_rd_q   <= 1'b1;
                ram_addr_q <= grant_addr;
                s1_q       <= OP_VID;
            end else if (grant_cpu) begin
                ram_addr_q <= grant_addr;
                if (bus.i_CPU_WE) begin
                    ram_wr_q  <= 1'b1;
                    ram_din_q <= bus.i_CPU_DIN;
                    s1_q      <= OP_CPU_WR;
                end else begin
                    ram_rd_q <= 1'b1;
                    s1_q     <= OP_CPU_RD;
                end
            end
        end
    end

    assign bus.o_RAM_ADDR  = ram_addr_q;
    assign bus.o_RAM_DIN   = ram_din_q;
    assign bus.o_RAM_RD    = ram_rd_q;
    assign bus.o_RAM_WR    = ram_wr_q;
    assign bus.o_VID_DATA  = vid_data_q;
    assign bus.o_VID_VALID = vid_valid_q;
    assign bus.o_CPU_DOUT  = cpu_dout_q;
    assign bus.o_CPU_ACK   = cpu_ack_q;
    assign bus.o_INIT_BUSY = busy_q;
endmodule
